mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_align.sv | 59 +++++
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory controller: FSM states,
// access sizes, and the size decode from the pipeline control bits.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    function automatic size_e decodeSize(input logic memHalf, input logic memByte);
        size_e s;
        if (memByte) begin
            s = BYTE;
        end else if (memHalf) begin
            s = HALF;
        end else begin
            s = WORD;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic: store byte enables and data replication, plus load lane
// extraction with sign/zero extension. Purely combinational.
module mem_align
    import mem_ctrl_pkg::*;
#(
    parameter logic BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  stSize,
    input  logic [1:0]  stAddrLow,
    input  logic [31:0] storeData,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ldSize,
    input  logic [1:0]  ldAddrLow,
    input  logic        ldSignExt,
    input  logic [31:0] rdata,
    output logic [31:0] loadData
);

    logic [3:0]  beLe;
    logic [1:0]  laneIdx;
    logic        halfHigh;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        beLe  = 4'b1111;
        wdata = storeData;
        case (stSize)
            BYTE: begin
                beLe  = 4'b0001 << stAddrLow;
                wdata = {4{storeData[7:0]}};
            end
            HALF: begin
                beLe  = stAddrLow[1] ? 4'b1100 : 4'b0011;
                wdata = {2{storeData[15:0]}};
            end
            default: begin
                beLe  = 4'b1111;
                wdata = storeData;
            end
        endcase
        // Big-endian puts byte address 0 on the most significant lane.
        be = BIG_ENDIAN ? {beLe[0], beLe[1], beLe[2], beLe[3]} : beLe;
    end

    always_comb begin
        laneIdx  = BIG_ENDIAN ? ~ldAddrLow : ldAddrLow;
        halfHigh = BIG_ENDIAN ? ~ldAddrLow[1] : ldAddrLow[1];
        byteVal  = rdata[{laneIdx, 3'b000} +: 8];
        halfVal  = halfHigh ? rdata[31:16] : rdata[15:0];
        case (ldSize)
            BYTE:    loadData = {{24{ldSignExt & byteVal[7]}}, byteVal};
            HALF:    loadData = {{16{ldSignExt & halfVal[15]}}, halfVal};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: stalls the pipeline across a
// request/acknowledge bus transaction and tracks the LL/SC link register.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic BIG_ENDIAN = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemHalf,
    input  logic        MemByte,
    input  logic        MemSignExtend,
    input  logic        LLSC,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic [31:0] LoadData,
    output logic        ScSuccess,
    output logic        StallController,
    output logic        AddrErrLoad,
    output logic        AddrErrStore,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [1:0]  dbgState,
    output logic        dbgLinkValid
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]  state, stateNext;
    logic [1:0]  size;
    logic        inIdle, inReq, inDone;
    logic        isLl, isSc, misaligned, linkHit, accessValid, scFail;
    logic        linkValid;
    logic [29:0] linkAddr;
    logic [29:0] addrQ;
    logic [1:0]  addrLowQ, sizeQ;
    logic        weQ, sextQ, llQ, scQ, flushedQ, scOkQ;
    logic [3:0]  beQ;
    logic [31:0] wdataQ, loadDataQ;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata, alignLoad;

    assign size        = decodeSize(MemHalf, MemByte);
    assign inIdle      = (state == ST_IDLE);
    assign inReq       = (state == ST_REQ);
    assign inDone      = (state == ST_DONE);
    assign isLl        = LLSC & MemRead;
    assign isSc        = LLSC & MemWrite;
    assign misaligned  = ((size == HALF) & Addr[0]) | ((size == WORD) & (|Addr[1:0]));
    assign linkHit     = linkValid & (linkAddr == Addr[31:2]);
    assign accessValid = (MemRead | MemWrite) & ~Flush & ~misaligned & ~(isSc & ~linkHit);
    assign scFail      = isSc & ~Flush & ~misaligned & ~linkHit;

    mem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .stSize    (size),
        .stAddrLow (Addr[1:0]),
        .storeData (StoreData),
        .be        (alignBe),
        .wdata     (alignWdata),
        .ldSize    (sizeQ),
        .ldAddrLow (addrLowQ),
        .ldSignExt (sextQ),
        .rdata     (dm_rdata),
        .loadData  (alignLoad)
    );

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (accessValid) stateNext = ST_REQ;
                else if (scFail) stateNext = ST_DONE;
            end
            ST_REQ: begin
                if (dm_ack) stateNext = (flushedQ | Flush) ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (Flush | ~Stall) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            linkValid <= 1'b0;
            linkAddr  <= '0;
            addrQ     <= '0;
            addrLowQ  <= '0;
            sizeQ     <= '0;
            weQ       <= 1'b0;
            sextQ     <= 1'b0;
            llQ       <= 1'b0;
            scQ       <= 1'b0;
            beQ       <= '0;
            wdataQ    <= '0;
            flushedQ  <= 1'b0;
            scOkQ     <= 1'b0;
            loadDataQ <= '0;
        end else begin
            state <= stateNext;
            if (inIdle) begin
                flushedQ <= 1'b0;
                scOkQ    <= 1'b0;
                if (accessValid) begin
                    addrQ    <= Addr[31:2];
                    addrLowQ <= Addr[1:0];
                    sizeQ    <= size;
                    weQ      <= MemWrite;
                    sextQ    <= MemSignExtend;
                    llQ      <= isLl;
                    scQ      <= isSc;
                    beQ      <= alignBe;
                    wdataQ   <= alignWdata;
                end
            end
            if (inReq && Flush) flushedQ <= 1'b1;
            // A flushed transaction still finishes on the bus, but its result is dropped.
            if (inReq && dm_ack && !(flushedQ || Flush)) begin
                if (!weQ) loadDataQ <= alignLoad;
                scOkQ <= scQ;
            end
            if (Flush) begin
                linkValid <= 1'b0;
            end else if (inReq && dm_ack) begin
                if (weQ && (scQ || addrQ == linkAddr)) begin
                    linkValid <= 1'b0;
                end else if (llQ && !flushedQ) begin
                    linkValid <= 1'b1;
                    linkAddr  <= addrQ;
                end
            end
        end
    end

    // Bus handshake: dm_req is the valid; it and all bus fields stay constant
    // from the first REQ cycle up to and including the cycle dm_ack is high.
    assign dm_req          = inReq;
    assign dm_we           = inReq & weQ;
    assign dm_addr         = inReq ? {addrQ, 2'b00} : 32'd0;
    assign dm_be           = inReq ? beQ : 4'd0;
    assign dm_wdata        = inReq ? wdataQ : 32'd0;
    assign StallController = inReq | (inIdle & (accessValid | scFail));
    assign AddrErrLoad     = inIdle & MemRead & misaligned;
    assign AddrErrStore    = inIdle & MemWrite & misaligned;
    assign LoadData        = loadDataQ;
    assign ScSuccess       = inDone & scOkQ;
    assign dbgState        = state;
    assign dbgLinkValid    = linkValid;

endmodule
